// File: rtl/ddr3_cmd_arb.sv
// Two-requester round-robin arbiter for the DDR3 PHY command port, with an
// in-order owner-tag FIFO that steers returned read data to the issuing requester.
module ddr3_cmd_arb #(
  parameter int unsigned p_TAG_AW    = 3,
  parameter int unsigned p_TAG_DEPTH = 8
) (
  input  logic                i_clk_div,
  input  logic                i_rst,

  input  logic                i_rq0_cmd_en,
  input  logic                i_rq0_cmd_sel,
  input  logic [2:0]          i3_rq0_bank,
  input  logic [13:0]         i14_rq0_row,
  input  logic [9:0]          i10_rq0_col,
  input  logic [127:0]        i128_rq0_wrdata,
  input  logic [7:0]          i8_rq0_wrdm,
  output logic                o_rq0_cmd_rdy,
  output logic                o_rq0_rddata_valid,

  input  logic                i_rq1_cmd_en,
  input  logic                i_rq1_cmd_sel,
  input  logic [2:0]          i3_rq1_bank,
  input  logic [13:0]         i14_rq1_row,
  input  logic [9:0]          i10_rq1_col,
  input  logic [127:0]        i128_rq1_wrdata,
  input  logic [7:0]          i8_rq1_wrdm,
  output logic                o_rq1_cmd_rdy,
  output logic                o_rq1_rddata_valid,

  output logic [127:0]        o128_rq_rddata,

  input  logic                i_phy_init_done,
  input  logic                i_phy_cmd_full,
  output logic                o_phy_cmd_en,
  output logic                o_phy_cmd_sel,
  output logic [2:0]          o3_phy_bank,
  output logic [13:0]         o14_phy_row,
  output logic [9:0]          o10_phy_col,
  output logic [127:0]        o128_phy_wrdata,
  output logic [7:0]          o8_phy_wrdm,

  input  logic                i_phy_rddata_valid,
  input  logic [127:0]        in_phy_rddata,

  output logic                o_tag_err,
  output logic [p_TAG_AW:0]   o_rd_outstanding
);

  localparam logic [p_TAG_AW:0] c_TAG_FULL = (p_TAG_AW + 1)'(p_TAG_DEPTH);

  logic                 r_last_grant;
  logic [p_TAG_AW-1:0]  r_wr_ptr;
  logic [p_TAG_AW-1:0]  r_rd_ptr;
  logic [p_TAG_AW:0]    r_count;
  logic [p_TAG_DEPTH-1:0] r_tag_mem;

  logic g;
  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic win0;
  logic win1;
  logic grant;
  logic win_sel;
  logic push;
  logic pop;
  logic head_owner;

  // Reset also gates grants so nothing is reported accepted while state is cleared.
  always_comb begin
    g          = i_phy_init_done & ~i_phy_cmd_full & ~i_rst;
    fifo_full  = (r_count == c_TAG_FULL);
    fifo_empty = (r_count == '0);
    elig0      = i_rq0_cmd_en & g & ~(i_rq0_cmd_sel & fifo_full);
    elig1      = i_rq1_cmd_en & g & ~(i_rq1_cmd_sel & fifo_full);
    // On a tie the requester that did not win last time takes the grant.
    win0       = elig0 & (~elig1 | r_last_grant);
    win1       = elig1 & (~elig0 | ~r_last_grant);
    grant      = win0 | win1;
    win_sel    = win1 ? i_rq1_cmd_sel : i_rq0_cmd_sel;
    push       = grant & win_sel;
    pop        = i_phy_rddata_valid & ~fifo_empty;
    head_owner = r_tag_mem[r_rd_ptr];
  end

  assign o_rq0_cmd_rdy    = win0;
  assign o_rq1_cmd_rdy    = win1;
  assign o_rd_outstanding = r_count;

  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (grant) begin
      r_last_grant <= win1;
    end
  end

  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      o_phy_cmd_en    <= 1'b0;
      o_phy_cmd_sel   <= 1'b0;
      o3_phy_bank     <= '0;
      o14_phy_row     <= '0;
      o10_phy_col     <= '0;
      o128_phy_wrdata <= '0;
      o8_phy_wrdm     <= '0;
    end else begin
      o_phy_cmd_en <= grant;
      if (win1) begin
        o_phy_cmd_sel   <= i_rq1_cmd_sel;
        o3_phy_bank     <= i3_rq1_bank;
        o14_phy_row     <= i14_rq1_row;
        o10_phy_col     <= i10_rq1_col;
        o128_phy_wrdata <= i128_rq1_wrdata;
        o8_phy_wrdm     <= i8_rq1_wrdm;
      end else if (win0) begin
        o_phy_cmd_sel   <= i_rq0_cmd_sel;
        o3_phy_bank     <= i3_rq0_bank;
        o14_phy_row     <= i14_rq0_row;
        o10_phy_col     <= i10_rq0_col;
        o128_phy_wrdata <= i128_rq0_wrdata;
        o8_phy_wrdm     <= i8_rq0_wrdm;
      end
    end
  end

  // Push cannot collide with the head slot: a push needs the FIFO not full, so
  // with any entries present the write pointer differs from the read pointer.
  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      r_tag_mem <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (push) begin
        r_tag_mem[r_wr_ptr] <= win1;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        r_count <= r_count + 1'b1;
      end else if (pop && !push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      o_rq0_rddata_valid <= 1'b0;
      o_rq1_rddata_valid <= 1'b0;
      o128_rq_rddata     <= '0;
      o_tag_err          <= 1'b0;
    end else begin
      o_rq0_rddata_valid <= pop & ~head_owner;
      o_rq1_rddata_valid <= pop & head_owner;
      if (pop) begin
        o128_rq_rddata <= in_phy_rddata;
      end
      if (i_phy_rddata_valid && fifo_empty) begin
        o_tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Self-checking bench for ddr3_cmd_arb: directed scenarios plus a randomized run
// checked against a queue-based reference model of the arbiter.
module tb_ddr3_cmd_arb;

  localparam int DEPTH = 8;

  logic         clk;
  logic         rst;
  logic         rq_en     [2];
  logic         rq_sel    [2];
  logic [2:0]   rq_bank   [2];
  logic [13:0]  rq_row    [2];
  logic [9:0]   rq_col    [2];
  logic [127:0] rq_wrdata [2];
  logic [7:0]   rq_wrdm   [2];
  logic         rdy0, rdy1, v0, v1;
  logic [127:0] rq_rddata;
  logic         init_done, cmd_full;
  logic         phy_en, phy_sel;
  logic [2:0]   phy_bank;
  logic [13:0]  phy_row;
  logic [9:0]   phy_col;
  logic [127:0] phy_wrdata;
  logic [7:0]   phy_wrdm;
  logic         phy_rdv;
  logic [127:0] phy_rd;
  logic         tag_err;
  logic [3:0]   outstanding;
  logic [163:0] dut_cmd;

  int errors;
  int checks;

  // Reference model state
  int           owner_q[$];
  int           last_win;
  bit           exp_en;
  logic [163:0] exp_cmd;
  bit           exp_v[2];
  logic [127:0] exp_rd;
  bit           exp_err;

  assign dut_cmd = {phy_sel, phy_bank, phy_row, phy_col, phy_wrdata, phy_wrdm};

  ddr3_cmd_arb #(.p_TAG_AW(3), .p_TAG_DEPTH(DEPTH)) dut (
    .i_clk_div          (clk),
    .i_rst              (rst),
    .i_rq0_cmd_en       (rq_en[0]),
    .i_rq0_cmd_sel      (rq_sel[0]),
    .i3_rq0_bank        (rq_bank[0]),
    .i14_rq0_row        (rq_row[0]),
    .i10_rq0_col        (rq_col[0]),
    .i128_rq0_wrdata    (rq_wrdata[0]),
    .i8_rq0_wrdm        (rq_wrdm[0]),
    .o_rq0_cmd_rdy      (rdy0),
    .o_rq0_rddata_valid (v0),
    .i_rq1_cmd_en       (rq_en[1]),
    .i_rq1_cmd_sel      (rq_sel[1]),
    .i3_rq1_bank        (rq_bank[1]),
    .i14_rq1_row        (rq_row[1]),
    .i10_rq1_col        (rq_col[1]),
    .i128_rq1_wrdata    (rq_wrdata[1]),
    .i8_rq1_wrdm        (rq_wrdm[1]),
    .o_rq1_cmd_rdy      (rdy1),
    .o_rq1_rddata_valid (v1),
    .o128_rq_rddata     (rq_rddata),
    .i_phy_init_done    (init_done),
    .i_phy_cmd_full     (cmd_full),
    .o_phy_cmd_en       (phy_en),
    .o_phy_cmd_sel      (phy_sel),
    .o3_phy_bank        (phy_bank),
    .o14_phy_row        (phy_row),
    .o10_phy_col        (phy_col),
    .o128_phy_wrdata    (phy_wrdata),
    .o8_phy_wrdm        (phy_wrdm),
    .i_phy_rddata_valid (phy_rdv),
    .in_phy_rddata      (phy_rd),
    .o_tag_err          (tag_err),
    .o_rd_outstanding   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [163:0] cmd_vec(int n);
    return {rq_sel[n], rq_bank[n], rq_row[n], rq_col[n], rq_wrdata[n], rq_wrdm[n]};
  endfunction

  // Winner by the arbitration rules: eligible set, then alternate on a tie.
  function automatic int mdl_winner();
    bit e[2];
    for (int n = 0; n < 2; n++) begin
      e[n] = rq_en[n] && init_done && !cmd_full && !rst &&
             !(rq_sel[n] && owner_q.size() == DEPTH);
    end
    if (e[0] && e[1]) return (last_win == 0) ? 1 : 0;
    if (e[0]) return 0;
    if (e[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_rdy(int w);
    return (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
  endfunction

  task automatic mdl_reset();
    owner_q.delete();
    last_win = 1;
    exp_en   = 0;
    exp_cmd  = '0;
    exp_v[0] = 0;
    exp_v[1] = 0;
    exp_rd   = '0;
    exp_err  = 0;
  endtask

  task automatic set_rq(int n, bit en, bit sel);
    rq_en[n]     = en;
    rq_sel[n]    = sel;
    rq_bank[n]   = 3'($urandom);
    rq_row[n]    = 14'($urandom);
    rq_col[n]    = 10'($urandom);
    rq_wrdata[n] = {$urandom, $urandom, $urandom, $urandom};
    rq_wrdm[n]   = 8'($urandom);
  endtask

  task automatic drive_idle();
    set_rq(0, 0, 0);
    set_rq(1, 0, 0);
    init_done = 1;
    cmd_full  = 0;
    phy_rdv   = 0;
    phy_rd    = '0;
  endtask

  // Advance one clock and the model with it; returns the winner of that edge.
  task automatic tick(output int w);
    int  pre;
    int  h;
    bit  pop;
    w   = mdl_winner();
    pre = owner_q.size();
    pop = phy_rdv && pre > 0;
    @(posedge clk);
    exp_v[0] = 0;
    exp_v[1] = 0;
    if (pop) begin
      h        = owner_q.pop_front();
      exp_v[h] = 1;
      exp_rd   = phy_rd;
    end
    if (phy_rdv && pre == 0) exp_err = 1;
    exp_en = (w >= 0);
    if (w >= 0) begin
      exp_cmd  = cmd_vec(w);
      last_win = w;
      if (rq_sel[w]) owner_q.push_back(w);
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    drive_idle();
    @(negedge clk);
    rst = 0;
    mdl_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy0, rdy1, phy_en, v0, v1, tag_err, outstanding} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0",
               {rdy0, rdy1, phy_en, v0, v1, tag_err, outstanding});
    end
    checks++;
    if (dut_cmd !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got %h want 0", dut_cmd);
    end
    checks++;
    if (rq_rddata !== '0) begin
      errors++;
      $display("FAIL reset_rddata: got %h want 0", rq_rddata);
    end
    @(negedge clk);
    rst = 0;
    mdl_reset();
  endtask

  task automatic test_alternate();
    int w;
    int accepted;
    apply_reset();
    accepted = 0;
    set_rq(0, 1, 0);
    set_rq(1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({rdy0, rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_rdy[%0d]: got %b want %b", i, {rdy0, rdy1},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick(w);
      if (w >= 0) begin
        accepted++;
        set_rq(w, 1, 0);
      end
      checks++;
      if (phy_en !== 1'b1 || dut_cmd !== exp_cmd) begin
        errors++;
        $display("FAIL alt_cmd[%0d]: got en=%b %h want en=1 %h", i, phy_en, dut_cmd, exp_cmd);
      end
    end
    checks++;
    if (accepted != 8) begin
      errors++;
      $display("FAIL alt_count: got %0d want 8", accepted);
    end
  endtask

  task automatic test_init_gate();
    int w;
    apply_reset();
    init_done = 0;
    set_rq(0, 1, 0);
    set_rq(1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({rdy0, rdy1} !== 2'b00) begin
        errors++;
        $display("FAIL init_rdy[%0d]: got %b want 00", i, {rdy0, rdy1});
      end
      tick(w);
      checks++;
      if (phy_en !== 1'b0) begin
        errors++;
        $display("FAIL init_en[%0d]: got %b want 0", i, phy_en);
      end
    end
    init_done = 1;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b10) begin
      errors++;
      $display("FAIL init_first: got %b want 10", {rdy0, rdy1});
    end
    tick(w);
    checks++;
    if (phy_en !== 1'b1 || dut_cmd !== exp_cmd) begin
      errors++;
      $display("FAIL init_cmd: got en=%b %h want en=1 %h", phy_en, dut_cmd, exp_cmd);
    end
  endtask

  task automatic test_fifo_full();
    int w;
    logic [127:0] data;
    apply_reset();
    set_rq(0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick(w);
      set_rq(0, 1, 1);
    end
    checks++;
    if (outstanding !== 4'd8) begin
      errors++;
      $display("FAIL full_occ: got %0d want 8", outstanding);
    end
    set_rq(1, 1, 0);
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b01) begin
      errors++;
      $display("FAIL full_block: got %b want 01", {rdy0, rdy1});
    end
    tick(w);
    set_rq(1, 0, 0);
    checks++;
    if (phy_en !== 1'b1 || phy_sel !== 1'b0) begin
      errors++;
      $display("FAIL full_wr: got en=%b sel=%b want en=1 sel=0", phy_en, phy_sel);
    end
    data    = {$urandom, $urandom, $urandom, $urandom};
    phy_rdv = 1;
    phy_rd  = data;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_rdy: got %b want 0", rdy0);
    end
    tick(w);
    phy_rdv = 0;
    checks++;
    if ({v0, v1} !== 2'b10 || rq_rddata !== data || outstanding !== 4'd7) begin
      errors++;
      $display("FAIL full_pop: got v=%b occ=%0d %h want v=10 occ=7 %h",
               {v0, v1}, outstanding, rq_rddata, data);
    end
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL full_unblock: got %b want 1", rdy0);
    end
    tick(w);
    checks++;
    if (outstanding !== 4'd8 || phy_en !== 1'b1 || phy_sel !== 1'b1) begin
      errors++;
      $display("FAIL full_regrant: got occ=%0d en=%b sel=%b want occ=8 en=1 sel=1",
               outstanding, phy_en, phy_sel);
    end
  endtask

  task automatic test_interleave();
    int w;
    int order[4];
    logic [3:0] nib;
    logic [127:0] want;
    order = '{0, 1, 1, 0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_rq(order[k], 1, 1);
      tick(w);
      set_rq(order[k], 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      nib     = 4'hA + 4'(k);
      phy_rdv = 1;
      phy_rd  = {32{nib}};
      want    = {32{nib}};
      tick(w);
      checks++;
      if ({v0, v1} !== ((order[k] == 0) ? 2'b10 : 2'b01) || rq_rddata !== want) begin
        errors++;
        $display("FAIL ilv_ret[%0d]: got v=%b %h want owner %0d %h",
                 k, {v0, v1}, rq_rddata, order[k], want);
      end
    end
    phy_rdv = 0;
    tick(w);
    checks++;
    if ({v0, v1} !== 2'b00 || rq_rddata !== {32{4'hD}} || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL ilv_hold: got v=%b occ=%0d %h want v=00 occ=0 d..d",
               {v0, v1}, outstanding, rq_rddata);
    end
  endtask

  task automatic test_simul();
    int w;
    int rest[4];
    rest = '{1, 0, 1, 1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_rq(k % 2, 1, 1);
      tick(w);
      set_rq(k % 2, 0, 0);
    end
    set_rq(1, 1, 1);
    phy_rdv = 1;
    phy_rd  = {4{32'h5151_0000}};
    tick(w);
    set_rq(1, 0, 0);
    phy_rdv = 0;
    checks++;
    if (outstanding !== 4'd4 || {v0, v1} !== 2'b10 || phy_en !== 1'b1) begin
      errors++;
      $display("FAIL simul: got occ=%0d v=%b en=%b want occ=4 v=10 en=1",
               outstanding, {v0, v1}, phy_en);
    end
    for (int k = 0; k < 4; k++) begin
      phy_rdv = 1;
      phy_rd  = {$urandom, $urandom, $urandom, $urandom};
      tick(w);
      checks++;
      if ({v0, v1} !== ((rest[k] == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL simul_drain[%0d]: got v=%b want owner %0d", k, {v0, v1}, rest[k]);
      end
    end
    phy_rdv = 0;
  endtask

  task automatic test_tag_err();
    int w;
    apply_reset();
    phy_rdv = 1;
    phy_rd  = {4{32'hDEAD_BEEF}};
    tick(w);
    phy_rdv = 0;
    checks++;
    if ({v0, v1} !== 2'b00 || tag_err !== 1'b1 || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL err_set: got v=%b err=%b occ=%0d want v=00 err=1 occ=0",
               {v0, v1}, tag_err, outstanding);
    end
    set_rq(0, 1, 1);
    repeat (3) tick(w);
    checks++;
    if (tag_err !== 1'b1 || phy_en !== 1'b1 || outstanding !== 4'd3) begin
      errors++;
      $display("FAIL err_hold: got err=%b en=%b occ=%0d want err=1 en=1 occ=3",
               tag_err, phy_en, outstanding);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({rdy0, rdy1, phy_en, v0, v1, tag_err, outstanding} !== 10'd0 ||
        dut_cmd !== '0 || rq_rddata !== '0) begin
      errors++;
      $display("FAIL async_rst: got %b %h want all 0",
               {rdy0, rdy1, phy_en, v0, v1, tag_err, outstanding}, dut_cmd);
    end
    @(negedge clk);
    rst = 0;
    mdl_reset();
    set_rq(0, 0, 0);
    phy_rdv = 1;
    tick(w);
    phy_rdv = 0;
    checks++;
    if (tag_err !== 1'b1 || {v0, v1} !== 2'b00) begin
      errors++;
      $display("FAIL stale_ret: got err=%b v=%b want err=1 v=00", tag_err, {v0, v1});
    end
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      cmd_full  = ($urandom_range(7) == 0);
      init_done = ($urandom_range(15) != 0);
      for (int n = 0; n < 2; n++) begin
        if (!rq_en[n] && $urandom_range(1) == 1) set_rq(n, 1, 1'($urandom));
      end
      if (owner_q.size() > 0) phy_rdv = ($urandom_range(2) == 0);
      else phy_rdv = ($urandom_range(63) == 0);
      phy_rd = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++;
      if ({rdy0, rdy1} !== exp_rdy(mdl_winner())) begin
        errors++;
        $display("FAIL rnd_rdy[%0d]: got %b want %b", c, {rdy0, rdy1}, exp_rdy(mdl_winner()));
      end
      tick(w);
      if (w >= 0) rq_en[w] = 0;
      checks++;
      if ({phy_en, v0, v1, tag_err, outstanding} !==
          {exp_en, exp_v[0], exp_v[1], exp_err, 4'(owner_q.size())}) begin
        errors++;
        $display("FAIL rnd_ctrl[%0d]: got %b want %b", c, {phy_en, v0, v1, tag_err, outstanding},
                 {exp_en, exp_v[0], exp_v[1], exp_err, 4'(owner_q.size())});
      end
      checks++;
      if (dut_cmd !== exp_cmd) begin
        errors++;
        $display("FAIL rnd_cmd[%0d]: got %h want %h", c, dut_cmd, exp_cmd);
      end
      checks++;
      if (rq_rddata !== exp_rd) begin
        errors++;
        $display("FAIL rnd_rd[%0d]: got %h want %h", c, rq_rddata, exp_rd);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1;
    test_reset();
    test_alternate();
    test_init_gate();
    test_fifo_full();
    test_interleave();
    test_simul();
    test_tag_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
